// File: rtl/rsa_pkg.sv
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared sizing and state encoding for the RSA byte loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rsa_pkg;

  localparam int KEY_BITS = 256;
  localparam int NBYTES   = KEY_BITS / 8;
  localparam int c_CNT_W  = $clog2(NBYTES);

  typedef logic [2:0] state_t;

  localparam state_t c_ST_GET_N = 3'd0;
  localparam state_t c_ST_GET_D = 3'd1;
  localparam state_t c_ST_GET_M = 3'd2;
  localparam state_t c_ST_START = 3'd3;
  localparam state_t c_ST_ARM   = 3'd4;
  localparam state_t c_ST_WAIT  = 3'd5;
  localparam state_t c_ST_SEND  = 3'd6;

  // Operand load order: N, then d, then M, then launch the core.
  function automatic state_t next_load_state(input state_t s);
    case (s)
      c_ST_GET_N: next_load_state = c_ST_GET_D;
      c_ST_GET_D: next_load_state = c_ST_GET_M;
      default:    next_load_state = c_ST_START;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rsa_byte_loader.sv
// ============================================================================
//  Module      : rsa_byte_loader
//  Description : Byte-stream loader for N/d/M, core launch and result unloader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsa_byte_loader
  import rsa_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                key_reload,
  output logic                core_start,
  output logic [KEY_BITS-1:0] core_N,
  output logic [KEY_BITS-1:0] core_d,
  output logic [KEY_BITS-1:0] core_M,
  input  logic                core_ready,
  input  logic [KEY_BITS-1:0] core_S,
  output logic                key_loaded,
  output logic                busy
);

  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NBYTES - 1);

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [KEY_BITS-1:0] r_n;
  logic [KEY_BITS-1:0] r_d;
  logic [KEY_BITS-1:0] r_m;
  logic [KEY_BITS-1:0] r_res;
  logic                r_key_loaded;

  logic                w_get;
  logic                w_last;
  logic                w_reload;
  logic [KEY_BITS-1:0] w_sel;
  logic [KEY_BITS-1:0] w_shifted;

  assign w_get  = (r_state == c_ST_GET_N) || (r_state == c_ST_GET_D) || (r_state == c_ST_GET_M);
  assign w_last = (r_cnt == c_LAST);

  // A reload at a word boundary of N or d would be a no-op or lose a finished N.
  assign w_reload = key_reload &&
                    ((r_state == c_ST_GET_M) ||
                     (((r_state == c_ST_GET_N) || (r_state == c_ST_GET_D)) && (r_cnt != '0)));

  always_comb begin
    w_sel = r_m;
    case (r_state)
      c_ST_GET_N: w_sel = r_n;
      c_ST_GET_D: w_sel = r_d;
      default:    w_sel = r_m;
    endcase
  end

  assign w_shifted = {w_sel[KEY_BITS-9:0], in_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_ST_GET_N;
      r_cnt        <= '0;
      r_n          <= '0;
      r_d          <= '0;
      r_m          <= '0;
      r_res        <= '0;
      r_key_loaded <= 1'b0;
    end else if (w_reload) begin
      r_state      <= c_ST_GET_N;
      r_cnt        <= '0;
      r_n          <= '0;
      r_d          <= '0;
      r_m          <= '0;
      r_key_loaded <= 1'b0;
    end else begin
      case (r_state)
        c_ST_GET_N, c_ST_GET_D, c_ST_GET_M: begin
          if (in_valid) begin
            case (r_state)
              c_ST_GET_N: r_n <= w_shifted;
              c_ST_GET_D: r_d <= w_shifted;
              default:    r_m <= w_shifted;
            endcase
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= next_load_state(r_state);
              if (r_state == c_ST_GET_D) r_key_loaded <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        c_ST_START: r_state <= c_ST_ARM;
        // core_ready may still be high from the previous run during ARM.
        c_ST_ARM:   r_state <= c_ST_WAIT;
        c_ST_WAIT: begin
          if (core_ready) begin
            r_res   <= core_S;
            r_state <= c_ST_SEND;
          end
        end
        c_ST_SEND: begin
          if (out_ready) begin
            r_res <= r_res << 8;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= c_ST_GET_M;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= c_ST_GET_N;
      endcase
    end
  end

  assign in_ready   = w_get;
  assign out_valid  = (r_state == c_ST_SEND);
  assign out_data   = r_res[KEY_BITS-1 -: 8];
  assign core_start = (r_state == c_ST_START);
  assign busy       = (r_state == c_ST_ARM) || (r_state == c_ST_WAIT) || (r_state == c_ST_SEND);
  assign key_loaded = r_key_loaded;
  assign core_N     = r_n;
  assign core_d     = r_d;
  assign core_M     = r_m;

endmodule

`default_nettype wire

// File: tb/tb_rsa_byte_loader.sv
// ============================================================================
//  Module      : tb_rsa_byte_loader
//  Description : Scoreboard bench for rsa_byte_loader with a modexp core model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rsa_byte_loader;

  logic         clk;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         key_reload;
  logic         core_start;
  logic [255:0] core_N;
  logic [255:0] core_d;
  logic [255:0] core_M;
  logic         core_ready;
  logic [255:0] core_S;
  logic         key_loaded;
  logic         busy;

  int           n_total;
  int           n_bad;
  int           n_starts;
  bit           stale_mode;
  logic [7:0]   sb[$];

  rsa_byte_loader u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .key_reload (key_reload),
    .core_start (core_start),
    .core_N     (core_N),
    .core_d     (core_d),
    .core_M     (core_M),
    .core_ready (core_ready),
    .core_S     (core_S),
    .key_loaded (key_loaded),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] modexp(input logic [255:0] b, input logic [255:0] e,
                                          input logic [255:0] n);
    logic [511:0] r;
    logic [511:0] base;
    logic [511:0] nn;
    if (n == '0) return '0;
    nn   = {256'b0, n};
    r    = 512'd1 % nn;
    base = {256'b0, b} % nn;
    for (int i = 255; i >= 0; i--) begin
      r = (r * r) % nn;
      if (e[i]) r = (r * base) % nn;
    end
    return r[255:0];
  endfunction

  task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Core model: result 10 cycles after start; in stale mode the old ready
  // level lingers through START and ARM.
  int           m_cnt;
  int           m_hold;
  logic [255:0] m_pend;
  always @(posedge clk) begin
    if (rst) begin
      core_ready <= 1'b0;
      core_S     <= '0;
      m_cnt  = 0;
      m_hold = 0;
    end else if (core_start) begin
      m_pend = modexp(core_M, core_d, core_N);
      m_cnt  = 10;
      m_hold = stale_mode ? 1 : 0;
      if (!stale_mode) core_ready <= 1'b0;
      n_starts++;
    end else begin
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) core_ready <= 1'b0;
      end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          core_ready <= 1'b1;
          core_S     <= m_pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check_val("sb_empty", 256'(sb.size()), 256'd1);
      end else begin
        check_val(out_ready ? "out_byte" : "stall_hold", {248'b0, out_data}, {248'b0, sb[0]});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_result(input logic [255:0] r);
    for (int i = 0; i < 32; i++) sb.push_back(r[255 - 8*i -: 8]);
  endtask

  task automatic send_bytes(input logic [255:0] w, input int n);
    logic [255:0] s;
    s = w;
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      in_data  = s[255:248];
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin
        step();
        t++;
      end
      if (t >= 200) check_val("in_ready_wait", {255'b0, in_ready}, 256'd1);
      step();
      s = s << 8;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int t;
    t = 0;
    while (core_ready && t < 100) begin step(); t++; end
    while (!core_ready && t < 100) begin step(); t++; end
    if (t >= 100) check_val("core_wait", 256'(t), 256'd0);
    step();
    check_val("first_out_valid", {255'b0, out_valid}, 256'd1);
  endtask

  task automatic drain(input bit bp);
    int t;
    t = 0;
    while (sb.size() > 0 && t < 2000) begin
      out_ready = bp ? (t % 3 == 0) : 1'b1;
      step();
      t++;
    end
    out_ready = 1'b1;
    check_val("drain_left", 256'(sb.size()), 256'd0);
    check_val("in_ready_after", {255'b0, in_ready}, 256'd1);
    check_val("busy_after", {255'b0, busy}, 256'd0);
  endtask

  logic [255:0] n2, d2, m2, m3, mpart;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_total = 0; n_bad = 0; n_starts = 0; stale_mode = 1'b0;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1; key_reload = 1'b0;
    repeat (3) step();
    check_val("rst_in_ready",   {255'b0, in_ready},   256'd1);
    check_val("rst_out_valid",  {255'b0, out_valid},  256'd0);
    check_val("rst_out_data",   {248'b0, out_data},   256'd0);
    check_val("rst_core_start", {255'b0, core_start}, 256'd0);
    check_val("rst_key_loaded", {255'b0, key_loaded}, 256'd0);
    check_val("rst_busy",       {255'b0, busy},       256'd0);
    rst = 1'b0;
    step();

    // Basic: 2^7 mod 77 = 51
    send_bytes(256'd77, 32);
    send_bytes(256'd7, 32);
    check_val("key_loaded_set", {255'b0, key_loaded}, 256'd1);
    push_result(256'h33);
    send_bytes(256'd2, 32);
    check_val("start_pulse", {255'b0, core_start}, 256'd1);
    check_val("core_N", core_N, 256'd77);
    check_val("core_d", core_d, 256'd7);
    check_val("core_M", core_M, 256'd2);
    step();
    check_val("start_drop", {255'b0, core_start}, 256'd0);
    check_val("arm_busy", {255'b0, busy}, 256'd1);
    check_val("arm_in_ready", {255'b0, in_ready}, 256'd0);
    wait_result();
    drain(1'b0);
    check_val("starts_basic", 256'(n_starts), 256'd1);

    // Key reuse: 3^7 mod 77 = 31
    push_result(256'h1F);
    send_bytes(256'd3, 32);
    check_val("reuse_start", {255'b0, core_start}, 256'd1);
    step();
    wait_result();
    drain(1'b0);
    check_val("reuse_key_loaded", {255'b0, key_loaded}, 256'd1);
    check_val("starts_reuse", 256'(n_starts), 256'd2);

    // Reload after 5 M bytes; the coincident byte must be dropped
    mpart = 256'hDEADBEEF01 << 216;
    send_bytes(mpart, 5);
    in_data = 8'hAA; in_valid = 1'b1; key_reload = 1'b1;
    step();
    key_reload = 1'b0; in_valid = 1'b0;
    check_val("reload_key_loaded", {255'b0, key_loaded}, 256'd0);
    check_val("reload_in_ready", {255'b0, in_ready}, 256'd1);
    check_val("reload_N", core_N, 256'd0);
    check_val("reload_M", core_M, 256'd0);

    // Fresh random key, result drained with backpressure
    for (int i = 0; i < 8; i++) begin
      n2[32*i +: 32] = $urandom;
      d2[32*i +: 32] = $urandom;
      m2[32*i +: 32] = $urandom;
      m3[32*i +: 32] = $urandom;
    end
    n2[255] = 1'b1; n2[0] = 1'b1;
    m2[255] = 1'b0; m3[255] = 1'b0; m3[0] = ~m2[0];
    send_bytes(n2, 32);
    send_bytes(d2, 32);
    push_result(modexp(m2, d2, n2));
    send_bytes(m2, 32);
    check_val("reload_start", {255'b0, core_start}, 256'd1);
    step();
    wait_result();
    drain(1'b1);

    // Stale core_ready from the previous run
    stale_mode = 1'b1;
    push_result(modexp(m3, d2, n2));
    send_bytes(m3, 32);
    check_val("stale_start", {255'b0, core_start}, 256'd1);
    step();
    wait_result();
    drain(1'b0);
    stale_mode = 1'b0;

    // Reset while SEND is mid-result
    push_result(modexp(256'd9, d2, n2));
    send_bytes(256'd9, 32);
    step();
    wait_result();
    repeat (4) step();
    check_val("send_4_popped", 256'(sb.size()), 256'd28);
    rst = 1'b1; out_ready = 1'b0;
    step();
    check_val("rst_send_out_valid",  {255'b0, out_valid},  256'd0);
    check_val("rst_send_in_ready",   {255'b0, in_ready},   256'd1);
    check_val("rst_send_busy",       {255'b0, busy},       256'd0);
    check_val("rst_send_key_loaded", {255'b0, key_loaded}, 256'd0);
    sb.delete();
    rst = 1'b0; out_ready = 1'b1;
    step();
    check_val("post_rst_out_data", {248'b0, out_data}, 256'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
